serial_subtractor: RTL

//  Bit-serial unsigned subtractor, the inverse operation of the half_adder datapath: diff = a - b over WIDTH bits.

---
 rtl/serial_arith_pkg.sv | 9 +
 rtl/serial_subtractor_full_subtractor.sv | 39 +++
 rtl/serial_subtractor.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// State encoding is shared with the serial adder.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational subtract cells in the same style as the half-adder cells.
// A full subtractor is two half subtractors plus an OR of their borrows.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d    = a ^ b;
  assign bout = ~a & b;
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs1 (
    .a    (d1),
    .b    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// Start/done handshake; result and borrow held until the next completion.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,      state_d;
  logic [WIDTH-1:0] a_sr_q,       a_sr_d;
  logic [WIDTH-1:0] b_sr_q,       b_sr_d;
  logic [WIDTH-1:0] diff_sr_q,    diff_sr_d;
  logic             borrow_q,     borrow_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic bit_d;
  logic bit_bout;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    diff_sr_d    = diff_sr_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      ST_SHIFT: begin
        diff_sr_d = {bit_d, diff_sr_q[WIDTH-1:1]};
        a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
        borrow_d  = bit_bout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          diff_d       = {bit_d, diff_sr_q[WIDTH-1:1]};
          borrow_out_d = bit_bout;
          cnt_d        = '0;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      // Unused encoding 2'd3 behaves exactly like IDLE
      default: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      diff_sr_q    <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      diff_sr_q    <= diff_sr_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
